stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Mode controller/sequencer for the stopwatch counter.
- Inputs: debounced button levels plus 1 Hz / 2 Hz tick strobes from the clock divider.
- Decides when the minutes:seconds counter advances, is adjusted or is cleared, and which field the display blinks.
- Sits between the debouncers/clock divider and the counter/display blocks; replaces ad-hoc enable logic inside the counter.

Parameters:
- STOP_AT_MAX, 1, 1 = when counting reaches 59:59, stop in PAUSED instead of wrapping; 0 = wrap.
- ADJ_STEP_ON_ENTRY, 1, 1 = issue one adjust increment on the cycle ADJ is entered, before the first 2 Hz tick.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, asynchronous assert, active-low. Sync release is handled upstream.
- pause_db  in  1  debounced pause button level.
- adj_db  in  1  debounced adjust switch level; high = adjust mode.
- sel_db  in  1  debounced select level; 0 = minutes, 1 = seconds.
- clr_db  in  1  debounced clear button level.
- tick_1hz  in  1  single-clk-cycle strobe at 1 Hz.
- tick_2hz  in  1  single-clk-cycle strobe at 2 Hz.
- at_max  in  1  counter currently at 59:59.
- cnt_en  out  1  one-cycle strobe: counter advances one second.
- inc_min  out  1  one-cycle strobe: minutes +1, mod 60.
- inc_sec  out  1  one-cycle strobe: seconds +1, mod 60, no carry into minutes.
- clr  out  1  one-cycle strobe: counter to 00:00.
- blink_min  out  1  display blinks the minutes field.
- blink_sec  out  1  display blinks the seconds field.
- state  out  2  encoded state, for debug/LED.

Behaviour:
- States: IDLE=0, RUN=1, PAUSED=2, ADJ=3.
- Reset (rst low): state=IDLE, ret_state=IDLE, all strobes 0, blink_* 0, edge-detect history registers 0.
- All outputs are registered.
- Rising edges of pause_db and clr_db are detected against a one-cycle-delayed copy. A level held high gives exactly one event. A press held through reset release does not fire, because history resets to 0 and the first sampled cycle is compared against that 0 only after reset deassert (history loads the current level on the first post-reset cycle, with no event).
- Event priority each cycle: clear > adj level > pause edge > tick.
- Clear edge, any state: next state=IDLE, clr=1 the following cycle, ret_state=IDLE. If adj_db is still high, ADJ is re-entered on the next cycle.
- adj_db=1 in IDLE/RUN/PAUSED: save current state to ret_state, go to ADJ.
- adj_db=0 in ADJ: return to ret_state. An ADJ entered from IDLE returns to PAUSED when any increment was issued during ADJ; otherwise it returns to IDLE.
- Pause edge: IDLE->RUN, RUN->PAUSED, PAUSED->RUN. Ignored in ADJ.
- RUN: tick_1hz gives cnt_en=1 one cycle later.
  - If at_max=1 on that tick and STOP_AT_MAX=1: no cnt_en; state->PAUSED.
  - STOP_AT_MAX=0: cnt_en issued; the counter wraps to 00:00.
- ADJ:
  - tick_2hz gives inc_min (sel_db=0) or inc_sec (sel_db=1) one cycle later.
  - With ADJ_STEP_ON_ENTRY=1, one increment is issued on the entry cycle.
  - sel_db changes take effect on the next tick. tick_1hz is ignored, so the counter is frozen.
  - Coincident tick_1hz and tick_2hz strobes are mutually exclusive in effect: at most one strobe is high per cycle.
- Blink: in ADJ, blink_min = ~sel_db and blink_sec = sel_db. In PAUSED, both are 1. Otherwise both are 0.
- Invariant: at most one of cnt_en, inc_min, inc_sec, clr is high in any cycle.
- Latency: input event at cycle n gives strobe/state at n+1.

Decomposition:
- Shared package stopwatch_pkg: state encoding constants (ST_IDLE, ST_RUN, ST_PAUSED, ST_ADJ) and the MAX_MIN/MAX_SEC = 59 constants, also used by the counter and display.
- One natural sub-module: edge_detect (1-bit rising-edge detector with async active-low reset), instantiated for pause and clear.

Test Plan:
- Reset mid-RUN with pause_db held high -> state=0 and all strobes 0 immediately. After release, no RUN entry until pause_db falls and rises again.
- IDLE, pause edge, then 3 tick_1hz pulses -> state=1 and exactly 3 cnt_en pulses, each 1 cycle after its tick. Second pause edge -> state=2, blink_min=blink_sec=1.
- RUN with at_max=1 and tick_1hz, STOP_AT_MAX=1 -> no cnt_en, state=2. Repeat with STOP_AT_MAX=0 -> one cnt_en, state stays 1.
- RUN, adj_db=1 with sel_db=1, 4 tick_2hz pulses, tick_1hz interleaved -> 5 inc_sec pulses (1 on entry + 4), 0 cnt_en, blink_sec=1. adj_db=0 -> state=1.
- ADJ from IDLE, sel_db=0, no ticks, ADJ_STEP_ON_ENTRY=0, release -> state=0. Same sequence with one tick_2hz -> one inc_min pulse, state=2 after release.
- Clear edge coincident with pause edge and tick_1hz in RUN -> clr=1 only, state=0, no cnt_en.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: state encoding, field limits
// and the display blink rule.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_ADJ    = 2'd3
    } state_t;

    localparam int unsigned MAX_MIN = 59;
    localparam int unsigned MAX_SEC = 59;

    // {blink_min, blink_sec} shown for a given state
    function automatic logic [1:0] blink_of(
        input state_t st,
        input logic   sel
    );
        logic [1:0] b;
        b = 2'b00;
        if (st == ST_ADJ) begin
            b = {~sel, sel};
        end else if (st == ST_PAUSED) begin
            b = 2'b11;
        end
        return b;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Controller-side bundle: debounced levels and ticks in,
// counter/display strobes and debug state out.
interface stopwatch_ctrl_if;

    logic       pause_db;
    logic       adj_db;
    logic       sel_db;
    logic       clr_db;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       at_max;
    logic       cnt_en;
    logic       inc_min;
    logic       inc_sec;
    logic       clr;
    logic       blink_min;
    logic       blink_sec;
    logic [1:0] state;

    modport master (
        output pause_db, adj_db, sel_db, clr_db,
        output tick_1hz, tick_2hz, at_max,
        input  cnt_en, inc_min, inc_sec, clr,
        input  blink_min, blink_sec, state
    );

    modport slave (
        input  pause_db, adj_db, sel_db, clr_db,
        input  tick_1hz, tick_2hz, at_max,
        output cnt_en, inc_min, inc_sec, clr,
        output blink_min, blink_sec, state
    );

endinterface

// File: rtl/stopwatch_ctrl_edge_detect.sv
// Rising-edge detector. The first cycle after reset only loads
// history, so a level held through reset never fires.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic prev;
    logic armed;

    // track previous level; arm after first post-reset sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= din;
            armed <= 1'b1;
        end
    end

    assign rise = armed & din & ~prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode sequencer: decides when the mm:ss counter
// advances, is adjusted or cleared, and what blinks.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter bit STOP_AT_MAX       = 1'b1,
    parameter bit ADJ_STEP_ON_ENTRY = 1'b1
) (
    input logic              clk,
    input logic              rst,
    stopwatch_ctrl_if.slave  bus
);

    state_t st;
    state_t ret_st;
    state_t adj_exit;
    logic   adj_inc;
    logic   pause_rise;
    logic   clr_rise;

    edge_detect u_pause (
        .clk   (clk),
        .rst_n (rst),
        .din   (bus.pause_db),
        .rise  (pause_rise)
    );

    edge_detect u_clr (
        .clk   (clk),
        .rst_n (rst),
        .din   (bus.clr_db),
        .rise  (clr_rise)
    );

    // an adjusted idle counter is no longer 00:00, so park it
    assign adj_exit = (ret_st == ST_IDLE && adj_inc) ?
                      ST_PAUSED : ret_st;

    assign bus.state = st;

    // mode FSM with registered strobes and blink flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st            <= ST_IDLE;
            ret_st        <= ST_IDLE;
            adj_inc       <= 1'b0;
            bus.cnt_en    <= 1'b0;
            bus.inc_min   <= 1'b0;
            bus.inc_sec   <= 1'b0;
            bus.clr       <= 1'b0;
            bus.blink_min <= 1'b0;
            bus.blink_sec <= 1'b0;
        end else begin
            bus.cnt_en  <= 1'b0;
            bus.inc_min <= 1'b0;
            bus.inc_sec <= 1'b0;
            bus.clr     <= 1'b0;
            {bus.blink_min, bus.blink_sec} <=
                blink_of(st, bus.sel_db);
            if (clr_rise) begin
                st      <= ST_IDLE;
                ret_st  <= ST_IDLE;
                adj_inc <= 1'b0;
                bus.clr <= 1'b1;
                {bus.blink_min, bus.blink_sec} <= 2'b00;
            end else if (bus.adj_db && st != ST_ADJ) begin
                ret_st  <= st;
                st      <= ST_ADJ;
                adj_inc <= ADJ_STEP_ON_ENTRY;
                if (ADJ_STEP_ON_ENTRY) begin
                    bus.inc_min <= ~bus.sel_db;
                    bus.inc_sec <= bus.sel_db;
                end
                {bus.blink_min, bus.blink_sec} <=
                    blink_of(ST_ADJ, bus.sel_db);
            end else if (!bus.adj_db && st == ST_ADJ) begin
                st <= adj_exit;
                {bus.blink_min, bus.blink_sec} <=
                    blink_of(adj_exit, bus.sel_db);
            end else begin
                unique case (st)
                    ST_IDLE: begin
                        if (pause_rise) begin
                            st <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (pause_rise) begin
                            st <= ST_PAUSED;
                            {bus.blink_min, bus.blink_sec} <= 2'b11;
                        end else if (bus.tick_1hz) begin
                            if (bus.at_max && STOP_AT_MAX) begin
                                st <= ST_PAUSED;
                                {bus.blink_min, bus.blink_sec} <= 2'b11;
                            end else begin
                                bus.cnt_en <= 1'b1;
                            end
                        end
                    end
                    ST_PAUSED: begin
                        if (pause_rise) begin
                            st <= ST_RUN;
                            {bus.blink_min, bus.blink_sec} <= 2'b00;
                        end
                    end
                    ST_ADJ: begin
                        if (bus.tick_2hz) begin
                            adj_inc     <= 1'b1;
                            bus.inc_min <= ~bus.sel_db;
                            bus.inc_sec <= bus.sel_db;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: two parameter sets driven
// in lockstep, expectations queued and checked after each edge.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    stopwatch_ctrl_if ifa ();
    stopwatch_ctrl_if ifb ();

    stopwatch_ctrl #(
        .STOP_AT_MAX       (1'b1),
        .ADJ_STEP_ON_ENTRY (1'b1)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    stopwatch_ctrl #(
        .STOP_AT_MAX       (1'b0),
        .ADJ_STEP_ON_ENTRY (1'b0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    localparam logic [3:0] NO   = 4'b0000;
    localparam logic [3:0] CNT  = 4'b1000;
    localparam logic [3:0] IMIN = 4'b0100;
    localparam logic [3:0] ISEC = 4'b0010;
    localparam logic [3:0] CLR  = 4'b0001;

    localparam logic [1:0] B0   = 2'b00;
    localparam logic [1:0] BP   = 2'b11;
    localparam logic [1:0] BMIN = 2'b10;
    localparam logic [1:0] BSEC = 2'b01;

    typedef struct {
        string      tag;
        logic [7:0] ea;
        logic [7:0] eb;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // {state, cnt_en, inc_min, inc_sec, clr, blink_min, blink_sec}
    function automatic logic [7:0] ov(
        input logic [1:0] st,
        input logic [3:0] stb,
        input logic [1:0] bl
    );
        return {st, stb, bl};
    endfunction

    function automatic logic [7:0] obs_a();
        return {ifa.state, ifa.cnt_en, ifa.inc_min, ifa.inc_sec,
                ifa.clr, ifa.blink_min, ifa.blink_sec};
    endfunction

    function automatic logic [7:0] obs_b();
        return {ifb.state, ifb.cnt_en, ifb.inc_min, ifb.inc_sec,
                ifb.clr, ifb.blink_min, ifb.blink_sec};
    endfunction

    task automatic drive(
        input bit p, input bit a, input bit s, input bit c,
        input bit t1, input bit t2, input bit m
    );
        ifa.pause_db = p;  ifb.pause_db = p;
        ifa.adj_db   = a;  ifb.adj_db   = a;
        ifa.sel_db   = s;  ifb.sel_db   = s;
        ifa.clr_db   = c;  ifb.clr_db   = c;
        ifa.tick_1hz = t1; ifb.tick_1hz = t1;
        ifa.tick_2hz = t2; ifb.tick_2hz = t2;
        ifa.at_max   = m;  ifb.at_max   = m;
    endtask

    task automatic pop_check();
        exp_t e;
        logic [7:0] oa;
        logic [7:0] ob;
        e  = sb.pop_front();
        oa = obs_a();
        ob = obs_b();
        checks++;
        assert (oa === e.ea) else begin
            errors++;
            $error("FAIL %s/A observed=%b expected=%b",
                   e.tag, oa, e.ea);
        end
        checks++;
        assert (ob === e.eb) else begin
            errors++;
            $error("FAIL %s/B observed=%b expected=%b",
                   e.tag, ob, e.eb);
        end
    endtask

    // one clock: inputs set at negedge, outputs sampled 1 after posedge
    task automatic step(
        input string tag,
        input bit p, input bit a, input bit s, input bit c,
        input bit t1, input bit t2, input bit m,
        input logic [7:0] ea, input logic [7:0] eb
    );
        exp_t e;
        @(negedge clk);
        drive(p, a, s, c, t1, t2, m);
        e.tag = tag;
        e.ea  = ea;
        e.eb  = eb;
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic check_now(input string tag, input logic [7:0] ex);
        exp_t e;
        e.tag = tag;
        e.ea  = ex;
        e.eb  = ex;
        sb.push_back(e);
        pop_check();
    endtask

    logic [7:0] run0, idl0, idlc, psd0;

    initial begin
        run0 = ov(2'd1, NO, B0);
        idl0 = ov(2'd0, NO, B0);
        idlc = ov(2'd0, CLR, B0);
        psd0 = ov(2'd2, NO, BP);

        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_now("reset", idl0);
        @(negedge clk);
        rst = 1'b1;

        //     tag     P A S C T1 T2 M
        step("arm",    0,0,0,0, 0,0,0, idl0, idl0);
        step("run",    1,0,0,0, 0,0,0, run0, run0);
        step("runh",   1,0,0,0, 0,0,0, run0, run0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check_now("rst_async", idl0);
        @(negedge clk);
        rst = 1'b1;

        step("rel0",   1,0,0,0, 0,0,0, idl0, idl0);
        step("rel1",   1,0,0,0, 0,0,0, idl0, idl0);
        step("rel2",   0,0,0,0, 0,0,0, idl0, idl0);
        step("repress",1,0,0,0, 0,0,0, run0, run0);

        step("tick1",  0,0,0,0, 1,0,0, ov(1,CNT,B0), ov(1,CNT,B0));
        step("gap1",   0,0,0,0, 0,0,0, run0, run0);
        step("tick2",  0,0,0,0, 1,0,0, ov(1,CNT,B0), ov(1,CNT,B0));
        step("gap2",   0,0,0,0, 0,0,0, run0, run0);
        step("tick3",  0,0,0,0, 1,0,0, ov(1,CNT,B0), ov(1,CNT,B0));
        step("gap3",   0,0,0,0, 0,0,0, run0, run0);
        step("pause",  1,0,0,0, 0,0,0, psd0, psd0);
        step("pausedh",0,0,0,0, 0,0,0, psd0, psd0);
        step("ptick",  0,0,0,0, 1,0,0, psd0, psd0);

        step("resume", 1,0,0,0, 0,0,0, run0, run0);
        step("atmax",  0,0,0,0, 1,0,1, psd0, ov(1,CNT,B0));
        step("clr1",   0,0,0,0, 0,0,0, psd0, run0);
        step("clr1b",  0,0,0,1, 0,0,0, idlc, idlc);
        step("clr1c",  0,0,0,0, 0,0,0, idl0, idl0);

        step("run2",   1,0,0,0, 0,0,0, run0, run0);
        step("run2h",  0,0,0,0, 0,0,0, run0, run0);
        step("adjin",  0,1,1,0, 0,0,0, ov(3,ISEC,BSEC), ov(3,NO,BSEC));
        step("adj_t2a",0,1,1,0, 0,1,0, ov(3,ISEC,BSEC), ov(3,ISEC,BSEC));
        step("adj_t1a",0,1,1,0, 1,0,0, ov(3,NO,BSEC), ov(3,NO,BSEC));
        step("adj_t2b",0,1,1,0, 0,1,0, ov(3,ISEC,BSEC), ov(3,ISEC,BSEC));
        step("adj_bth",0,1,1,0, 1,1,0, ov(3,ISEC,BSEC), ov(3,ISEC,BSEC));
        step("adj_t2d",0,1,1,0, 0,1,0, ov(3,ISEC,BSEC), ov(3,ISEC,BSEC));
        step("adj_t1b",0,1,1,0, 1,0,0, ov(3,NO,BSEC), ov(3,NO,BSEC));
        step("adjout", 0,0,1,0, 0,0,0, run0, run0);

        step("clr2",   0,0,0,1, 0,0,0, idlc, idlc);
        step("clr2b",  0,0,0,0, 0,0,0, idl0, idl0);
        step("adjidl", 0,1,0,0, 0,0,0, ov(3,IMIN,BMIN), ov(3,NO,BMIN));
        step("adjidlh",0,1,0,0, 0,0,0, ov(3,NO,BMIN), ov(3,NO,BMIN));
        step("adjidlx",0,0,0,0, 0,0,0, psd0, idl0);

        step("clr3",   0,0,0,1, 0,0,0, idlc, idlc);
        step("clr3b",  0,0,0,0, 0,0,0, idl0, idl0);
        step("adj2in", 0,1,0,0, 0,0,0, ov(3,IMIN,BMIN), ov(3,NO,BMIN));
        step("adj2t2", 0,1,0,0, 0,1,0, ov(3,IMIN,BMIN), ov(3,IMIN,BMIN));
        step("adj2out",0,0,0,0, 0,0,0, psd0, psd0);

        step("clradj", 0,1,0,1, 0,0,0, idlc, idlc);
        step("readj",  0,1,0,1, 0,0,0, ov(3,IMIN,BMIN), ov(3,NO,BMIN));
        step("readjx", 0,0,0,0, 0,0,0, psd0, idl0);
        step("clr4",   0,0,0,1, 0,0,0, idlc, idlc);
        step("clr4b",  0,0,0,0, 0,0,0, idl0, idl0);

        step("run3",   1,0,0,0, 0,0,0, run0, run0);
        step("run3h",  0,0,0,0, 0,0,0, run0, run0);
        step("clrpri", 1,0,0,1, 1,0,0, idlc, idlc);
        step("clrpri2",0,0,0,0, 0,0,0, idl0, idl0);

        step("adj3in", 0,1,1,0, 0,0,0, ov(3,ISEC,BSEC), ov(3,NO,BSEC));
        step("adj3p",  1,1,1,0, 0,0,0, ov(3,NO,BSEC), ov(3,NO,BSEC));
        step("adj3sel",1,1,0,0, 0,0,0, ov(3,NO,BMIN), ov(3,NO,BMIN));
        step("adj3t2", 1,1,0,0, 0,1,0, ov(3,IMIN,BMIN), ov(3,IMIN,BMIN));
        step("adj3out",0,0,0,0, 0,0,0, psd0, psd0);

        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_left observed=%0d expected=0",
                   sb.size());
        end
        checks++;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
